vfp_config_sequencer: RTL and testbench

- AXI4-Lite master that replays a table of (address, data) register writes onto the VFP vfpconfig slave port.
- Used by the test harness and bring-up logic to configure filters and modes (F_* select, thresholds) without a CPU.
- Optionally holds the sequence until an end-of-frame pulse, so configuration changes land between frames.
- Reports completion, AXI error responses and timeouts.

---
 rtl/vfp_config_sequencer_pkg.sv | 27 ++
 rtl/vfp_config_sequencer_if.sv | 37 +++
 rtl/vfp_config_table.sv | 26 ++
 rtl/vfp_config_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_vfp_config_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vfp_config_sequencer_pkg.sv
// rtl/vfp_config_sequencer_pkg.sv - shared types and constants for the config sequencer
// RD/RD_RESP states exist only when VFP_CFG_READBACK_EN is defined.
package vfp_config_sequencer_pkg;

  localparam int CFG_ADDR_W    = 8;
  localparam int CFG_DATA_W    = 32;
  localparam int CFG_TIMEOUT_W = 8;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef struct packed {
    logic [CFG_ADDR_W-1:0] addr;
    logic [CFG_DATA_W-1:0] data;
  } cfg_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_EOF,
    ST_WR,
    ST_WR_RESP,
`ifdef VFP_CFG_READBACK_EN
    ST_RD,
    ST_RD_RESP,
`endif
    ST_FIN
  } vfp_cfg_state_e;

endpackage

// File: rtl/vfp_config_sequencer_if.sv
// rtl/vfp_config_sequencer_if.sv - AXI4-Lite bundle toward the vfpconfig slave port
interface vfp_config_sequencer_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/vfp_config_table.sv
// rtl/vfp_config_table.sv - (address, data) register file, sync write / async read
// Contents survive reset on purpose: a table loaded once can be replayed after any reset.
module vfp_config_table
  import vfp_config_sequencer_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] wr_idx,
  input  cfg_entry_t                  wr_entry,
  input  logic [$clog2(NUM_REGS)-1:0] rd_idx,
  output cfg_entry_t                  rd_entry
);

  cfg_entry_t mem_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_idx] <= wr_entry;
    end
  end

  assign rd_entry = mem_q[rd_idx];

endmodule

// File: rtl/vfp_config_sequencer.sv
// rtl/vfp_config_sequencer.sv - replays a register-write table onto the vfpconfig AXI-Lite port
// Optional readback verification is enabled by defining VFP_CFG_READBACK_EN.
module vfp_config_sequencer
  import vfp_config_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tbl_we,
  input  logic [$clog2(NUM_REGS)-1:0] tbl_idx,
  input  logic [ADDR_WIDTH-1:0]       tbl_addr,
  input  logic [DATA_WIDTH-1:0]       tbl_data,
  input  logic [$clog2(NUM_REGS):0]   seq_len,
  input  logic                        start,
  input  logic                        frame_sync,
  input  logic                        eof,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [$clog2(NUM_REGS)-1:0] err_idx,
  vfp_config_sequencer_if.master      axi
);

  localparam int IDX_W = $clog2(NUM_REGS);

  vfp_cfg_state_e           state_q, state_d, adv_state;
  logic [IDX_W-1:0]         idx_q, idx_d, err_idx_q, err_idx_d;
  logic [IDX_W:0]           len_q, len_d, idx_inc;
  logic                     err_q, err_d;
  logic                     aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [CFG_TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                     awvalid_w, wvalid_w, aw_hs, w_hs, timed_out, tbl_wr_en;
  cfg_entry_t               entry, wr_entry;

  assign tbl_wr_en     = tbl_we & ~busy;
  assign wr_entry.addr = CFG_ADDR_W'(tbl_addr);
  assign wr_entry.data = CFG_DATA_W'(tbl_data);

  vfp_config_table #(.NUM_REGS(NUM_REGS)) u_table (
    .clk      (clk),
    .we       (tbl_wr_en),
    .wr_idx   (tbl_idx),
    .wr_entry (wr_entry),
    .rd_idx   (idx_q),
    .rd_entry (entry)
  );

  assign awvalid_w = (state_q == ST_WR) & ~aw_done_q;
  assign wvalid_w  = (state_q == ST_WR) & ~w_done_q;
  assign aw_hs     = awvalid_w & axi.awready;
  assign w_hs      = wvalid_w & axi.wready;
  assign timed_out = (cnt_q == CFG_TIMEOUT_W'(TIMEOUT));
  assign idx_inc   = {1'b0, idx_q} + 1'b1;
  assign adv_state = (idx_inc < len_q) ? ST_WR : ST_FIN;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          idx_d = '0;
          len_d = seq_len;
          if (seq_len == '0)   state_d = ST_FIN;
          else if (frame_sync) state_d = ST_WAIT_EOF;
          else                 state_d = ST_WR;
        end
      end
      ST_WAIT_EOF: begin
        if (eof) state_d = ST_WR;
      end
      ST_WR: begin
        // Each channel may complete in any cycle; both done (possibly together) ends the beat.
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          state_d   = ST_WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else if (timed_out) begin
          err_d     = 1'b1;
          err_idx_d = idx_q;
          state_d   = ST_FIN;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end
      ST_WR_RESP: begin
        if (axi.bvalid) begin
          if (axi.bresp != AXI_RESP_OKAY) begin
            err_d     = 1'b1;
            err_idx_d = idx_q;
            state_d   = ST_FIN;
          end else begin
`ifdef VFP_CFG_READBACK_EN
            state_d = ST_RD;
`else
            idx_d   = idx_q + 1'b1;
            state_d = adv_state;
`endif
          end
        end else if (timed_out) begin
          err_d     = 1'b1;
          err_idx_d = idx_q;
          state_d   = ST_FIN;
        end
      end
`ifdef VFP_CFG_READBACK_EN
      ST_RD: begin
        if (axi.arready) begin
          state_d = ST_RD_RESP;
        end else if (timed_out) begin
          err_d     = 1'b1;
          err_idx_d = idx_q;
          state_d   = ST_FIN;
        end
      end
      ST_RD_RESP: begin
        if (axi.rvalid) begin
          if ((axi.rresp != AXI_RESP_OKAY) || (axi.rdata != DATA_WIDTH'(entry.data))) begin
            err_d     = 1'b1;
            err_idx_d = idx_q;
            state_d   = ST_FIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = adv_state;
          end
        end else if (timed_out) begin
          err_d     = 1'b1;
          err_idx_d = idx_q;
          state_d   = ST_FIN;
        end
      end
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Reloads to 1 on every state entry so the count equals cycles spent in the current state.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)  cnt_d = CFG_TIMEOUT_W'(1);
    else if (cnt_q != '1)    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy    = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done    = (state_q == ST_FIN);
  assign error   = err_q;
  assign err_idx = err_idx_q;

  assign axi.awvalid = awvalid_w;
  assign axi.awaddr  = awvalid_w ? ADDR_WIDTH'(entry.addr) : '0;
  assign axi.awprot  = 3'b000;
  assign axi.wvalid  = wvalid_w;
  assign axi.wdata   = wvalid_w ? DATA_WIDTH'(entry.data) : '0;
  assign axi.wstrb   = '1;
  assign axi.bready  = (state_q == ST_WR_RESP);
  assign axi.arprot  = 3'b000;

`ifdef VFP_CFG_READBACK_EN
  assign axi.arvalid = (state_q == ST_RD);
  assign axi.araddr  = (state_q == ST_RD) ? ADDR_WIDTH'(entry.addr) : '0;
  assign axi.rready  = (state_q == ST_RD_RESP);
`else
  logic unused_rd_w;
  assign unused_rd_w = ^{axi.arready, axi.rdata, axi.rresp, axi.rvalid};
  assign axi.arvalid = 1'b0;
  assign axi.araddr  = '0;
  assign axi.rready  = 1'b0;
`endif

endmodule

// File: tb/tb_vfp_config_sequencer.sv
// tb/tb_vfp_config_sequencer.sv - randomized self-checking bench with a responsive AXI-Lite slave
module tb_vfp_config_sequencer;

`ifdef VFP_CFG_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, tbl_we, start, frame_sync, eof;
  logic [3:0]  tbl_idx;
  logic [7:0]  tbl_addr;
  logic [31:0] tbl_data;
  logic [4:0]  seq_len;
  logic        busy, done, error;
  logic [3:0]  err_idx;

  vfp_config_sequencer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) axi ();

  vfp_config_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .seq_len(seq_len), .start(start), .frame_sync(frame_sync), .eof(eof),
    .busy(busy), .done(done), .error(error), .err_idx(err_idx), .axi(axi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference table: what software believes it loaded.
  logic [7:0]  m_addr [16];
  logic [31:0] m_data [16];

  // Slave behaviour knobs and observations.
  int sl_aw_delay, sl_w_delay, sl_b_delay, sl_err_beat, sl_rd_bad;
  bit sl_hang_aw;
  int aw_cnt, w_cnt, b_cnt, b_num, r_num;
  int aw_hi, w_hi, ar_hi, rr_hi;
  logic [7:0]  got_aw [$];
  logic [31:0] got_w  [$];
  logic [7:0]  got_ar [$];

  initial begin
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    forever begin
      @(negedge clk);
      if (axi.awvalid === 1'b1) begin
        aw_hi++;
        if (!sl_hang_aw && aw_cnt == sl_aw_delay) begin
          axi.awready = 1; got_aw.push_back(axi.awaddr); aw_cnt = 0;
        end else begin
          axi.awready = 0; aw_cnt++;
        end
      end else begin
        axi.awready = 0; aw_cnt = 0;
      end
      if (axi.wvalid === 1'b1) begin
        w_hi++;
        if (w_cnt == sl_w_delay) begin
          axi.wready = 1; got_w.push_back(axi.wdata); w_cnt = 0;
        end else begin
          axi.wready = 0; w_cnt++;
        end
      end else begin
        axi.wready = 0; w_cnt = 0;
      end
      if (axi.bvalid) begin
        axi.bvalid = 0;
      end else if (axi.bready === 1'b1) begin
        if (b_cnt == sl_b_delay) begin
          axi.bvalid = 1;
          axi.bresp  = (b_num == sl_err_beat) ? 2'b10 : 2'b00;
          b_num++; b_cnt = 0;
        end else begin
          b_cnt++;
        end
      end else begin
        b_cnt = 0;
      end
      if (axi.arvalid === 1'b1) begin
        ar_hi++; axi.arready = 1; got_ar.push_back(axi.araddr);
      end else begin
        axi.arready = 0;
      end
      if (axi.rvalid) begin
        axi.rvalid = 0;
      end else if (axi.rready === 1'b1) begin
        rr_hi++;
        axi.rvalid = 1; axi.rresp = 2'b00;
        axi.rdata  = (r_num < 16) ? m_data[r_num] : 32'h0;
        if (r_num == sl_rd_bad) axi.rdata = axi.rdata ^ 32'h1;
        r_num++;
      end
    end
  end

  task automatic clear_slave(input int awd, input int wd, input int bd, input int errb,
                             input int rdbad, input bit hang);
    sl_aw_delay = awd; sl_w_delay = wd; sl_b_delay = bd; sl_err_beat = errb;
    sl_rd_bad = rdbad; sl_hang_aw = hang;
    b_num = 0; r_num = 0; aw_hi = 0; w_hi = 0; ar_hi = 0; rr_hi = 0;
    got_aw.delete(); got_w.delete(); got_ar.delete();
  endtask

  task automatic load_entry(input int i, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    tbl_we = 1; tbl_idx = 4'(i); tbl_addr = a; tbl_data = d;
    m_addr[i] = a; m_data[i] = d;
    @(negedge clk);
    tbl_we = 0;
  endtask

  task automatic load_basic();
    load_entry(0, 8'h00, 32'h1);
    load_entry(1, 8'h04, 32'hFF);
    load_entry(2, 8'h08, 32'h10);
  endtask

  // Starts a sequence and returns the number of cycles until done is seen, or -1.
  task automatic run_seq(input int len, output int lat);
    @(negedge clk);
    seq_len = 5'(len); frame_sync = 0; start = 1;
    lat = 0;
    do begin
      @(negedge clk); start = 0; lat++;
    end while (!done && lat < 1000);
    if (!done) lat = -1;
  endtask

  // Cycles from start to done: one to leave IDLE, per-beat write cost, two per readback.
  function automatic int exp_lat(input int n_wr, input int n_ok, input int wcost);
    return 1 + n_wr * wcost + RB * 2 * n_ok;
  endfunction

  task automatic test_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 0 || done !== 0 || error !== 0 || err_idx !== 0) begin
      errors++; $display("FAIL reset_status: busy=%b done=%b error=%b err_idx=%0d expected all 0", busy, done, error, err_idx); end
    checks++; if (axi.awvalid !== 0 || axi.wvalid !== 0 || axi.bready !== 0 || axi.arvalid !== 0 || axi.rready !== 0) begin
      errors++; $display("FAIL reset_valids: aw=%b w=%b b=%b ar=%b r=%b expected 0", axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready); end
    checks++; if (axi.wstrb !== 4'hF || axi.awaddr !== 0 || axi.wdata !== 0 || axi.awprot !== 0) begin
      errors++; $display("FAIL reset_bus: wstrb=%h awaddr=%h wdata=%h awprot=%h expected F/0/0/0", axi.wstrb, axi.awaddr, axi.wdata, axi.awprot); end
    reset = 0;
  endtask

  task automatic test_basic();
    int lat;
    load_basic();
    clear_slave(0, 0, 0, -1, -1, 0);
    run_seq(3, lat);
    checks++; if (lat != exp_lat(3, 3, 2)) begin
      errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, exp_lat(3, 3, 2)); end
    checks++; if (got_aw.size() != 3 || got_w.size() != 3) begin
      errors++; $display("FAIL basic_beats: aw=%0d w=%0d expected 3", got_aw.size(), got_w.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (got_aw[i] !== m_addr[i] || got_w[i] !== m_data[i]) begin
        errors++; $display("FAIL basic_beat%0d: got %h/%h expected %h/%h", i, got_aw[i], got_w[i], m_addr[i], m_data[i]); end
    end
    checks++; if (error !== 0) begin
      errors++; $display("FAIL basic_error: got %b expected 0", error); end
  endtask

  task automatic test_aw_delay();
    int lat;
    clear_slave(3, 0, 0, -1, -1, 0);
    run_seq(1, lat);
    checks++; if (aw_hi != 4 || w_hi != 1) begin
      errors++; $display("FAIL aw_delay_hold: awvalid %0d wvalid %0d cycles expected 4 and 1", aw_hi, w_hi); end
    checks++; if (got_aw.size() != 1 || got_w.size() != 1 || lat != exp_lat(1, 1, 5)) begin
      errors++; $display("FAIL aw_delay_count: aw=%0d w=%0d lat=%0d expected 1 1 %0d", got_aw.size(), got_w.size(), lat, exp_lat(1, 1, 5)); end
  endtask

  task automatic test_bresp_error();
    int lat;
    clear_slave(0, 0, 0, 1, -1, 0);
    run_seq(3, lat);
    checks++; if (error !== 1 || err_idx !== 4'd1) begin
      errors++; $display("FAIL bresp_err: error=%b err_idx=%0d expected 1 and 1", error, err_idx); end
    checks++; if (got_aw.size() != 2 || lat != exp_lat(2, 1, 2)) begin
      errors++; $display("FAIL bresp_stop: aw=%0d lat=%0d expected 2 and %0d", got_aw.size(), lat, exp_lat(2, 1, 2)); end
  endtask

  task automatic test_timeout();
    int lat;
    clear_slave(0, 0, 0, -1, -1, 1);
    run_seq(2, lat);
    checks++; if (lat != 256 || aw_hi != 255) begin
      errors++; $display("FAIL timeout_len: lat=%0d awvalid_cycles=%0d expected 256 and 255", lat, aw_hi); end
    checks++; if (error !== 1 || err_idx !== 0 || axi.awvalid !== 0 || got_aw.size() != 0) begin
      errors++; $display("FAIL timeout_state: error=%b err_idx=%0d awvalid=%b aw=%0d expected 1 0 0 0", error, err_idx, axi.awvalid, got_aw.size()); end
    sl_hang_aw = 0;
  endtask

  task automatic test_frame_sync();
    int bad, lat;
    clear_slave(0, 0, 0, -1, -1, 0);
    @(negedge clk);
    seq_len = 5'd1; frame_sync = 1; start = 1; eof = 1;
    @(negedge clk);
    start = 0; eof = 0; frame_sync = 0;
    bad = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clk);
      if (axi.awvalid !== 0 || busy !== 1) bad++;
      if (c == 10) eof = 1;
    end
    @(negedge clk);
    eof = 0;
    checks++; if (bad != 0) begin
      errors++; $display("FAIL fsync_hold: %0d early cycles with awvalid or !busy, expected 0", bad); end
    checks++; if (axi.awvalid !== 1) begin
      errors++; $display("FAIL fsync_release: awvalid=%b one cycle after eof, expected 1", axi.awvalid); end
    lat = 0;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    checks++; if (done !== 1 || got_aw.size() != 1 || got_aw[0] !== m_addr[0]) begin
      errors++; $display("FAIL fsync_done: done=%b aw=%0d expected 1 and 1", done, got_aw.size()); end
  endtask

  task automatic test_zero_len();
    int lat;
    clear_slave(0, 0, 0, -1, -1, 0);
    run_seq(0, lat);
    checks++; if (lat != 1 || busy !== 0 || aw_hi != 0 || w_hi != 0) begin
      errors++; $display("FAIL zero_len: lat=%0d busy=%b aw=%0d w=%0d expected 1 0 0 0", lat, busy, aw_hi, w_hi); end
    @(negedge clk);
    checks++; if (done !== 0) begin
      errors++; $display("FAIL zero_len_pulse: done=%b on second cycle expected 0", done); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    load_entry(3, 8'h0C, 32'h1234_5678);
    clear_slave(2, 0, 0, -1, -1, 0);
    @(negedge clk);
    seq_len = 5'd4; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    start = 1; seq_len = 5'd1; tbl_we = 1; tbl_idx = 4'd3; tbl_addr = 8'hEE; tbl_data = ~m_data[3];
    @(negedge clk);
    start = 0; tbl_we = 0; lat = 3;
    while (!done && lat < 1000) begin @(negedge clk); lat++; end
    checks++; if (lat != exp_lat(4, 4, 4) || got_aw.size() != 4) begin
      errors++; $display("FAIL busy_start: lat=%0d aw=%0d expected %0d and 4", lat, got_aw.size(), exp_lat(4, 4, 4)); end
    else begin
      checks++; if (got_aw[3] !== m_addr[3] || got_w[3] !== m_data[3]) begin
        errors++; $display("FAIL busy_tbl_we: got %h/%h expected %h/%h", got_aw[3], got_w[3], m_addr[3], m_data[3]); end
    end
  endtask

  task automatic test_mid_reset();
    int dn;
    clear_slave(0, 0, 0, -1, -1, 1);
    @(negedge clk);
    seq_len = 5'd2; start = 1;
    @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    checks++; if (axi.awvalid !== 0 || axi.bready !== 0 || busy !== 0) begin
      errors++; $display("FAIL mid_reset_drop: awvalid=%b bready=%b busy=%b expected 0", axi.awvalid, axi.bready, busy); end
    dn = 0;
    for (int c = 0; c < 6; c++) begin
      if (done !== 0) dn++;
      @(negedge clk);
    end
    checks++; if (dn != 0 || error !== 0) begin
      errors++; $display("FAIL mid_reset_quiet: done cycles=%0d error=%b expected 0 0", dn, error); end
    sl_hang_aw = 0;
  endtask

  task automatic test_readback();
    int lat;
    load_basic();
`ifdef VFP_CFG_READBACK_EN
    clear_slave(0, 0, 0, -1, 1, 0);
    run_seq(3, lat);
    checks++; if (error !== 1 || err_idx !== 4'd1 || lat != exp_lat(2, 2, 2)) begin
      errors++; $display("FAIL rb_mismatch: error=%b err_idx=%0d lat=%0d expected 1 1 %0d", error, err_idx, lat, exp_lat(2, 2, 2)); end
    checks++; if (got_ar.size() != 2 || got_ar[1] !== m_addr[1]) begin
      errors++; $display("FAIL rb_addr: reads=%0d expected 2 at %h", got_ar.size(), m_addr[1]); end
    clear_slave(0, 0, 0, -1, -1, 0);
    run_seq(3, lat);
    checks++; if (error !== 0 || lat != exp_lat(3, 3, 2)) begin
      errors++; $display("FAIL rb_match: error=%b lat=%0d expected 0 %0d", error, lat, exp_lat(3, 3, 2)); end
`else
    clear_slave(0, 0, 0, -1, -1, 0);
    run_seq(3, lat);
    checks++; if (ar_hi != 0 || rr_hi != 0 || axi.araddr !== 0 || axi.arprot !== 0) begin
      errors++; $display("FAIL rd_tied: arvalid cycles=%0d rready cycles=%0d araddr=%h expected 0", ar_hi, rr_hi, axi.araddr); end
    checks++; if (lat != exp_lat(3, 3, 2)) begin
      errors++; $display("FAIL rd_tied_lat: got %0d expected %0d", lat, exp_lat(3, 3, 2)); end
`endif
  endtask

  task automatic test_random();
    int len, errb, awd, wd, bd, n_wr, n_ok, lat, bad;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 16; i++) load_entry(i, 8'($urandom), $urandom);
      len  = (it == 7) ? 16 : int'($urandom_range(1, 16));
      errb = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, len - 1));
      awd  = $urandom_range(0, 3);
      wd   = $urandom_range(0, 3);
      bd   = $urandom_range(0, 3);
      n_wr = (errb < 0) ? len : errb + 1;
      n_ok = (errb < 0) ? len : errb;
      clear_slave(awd, wd, bd, errb, -1, 0);
      run_seq(len, lat);
      checks++; if (lat != exp_lat(n_wr, n_ok, ((awd > wd) ? awd : wd) + bd + 2)) begin
        errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, lat, exp_lat(n_wr, n_ok, ((awd > wd) ? awd : wd) + bd + 2)); end
      checks++; if (got_aw.size() != n_wr || got_w.size() != n_wr || got_ar.size() != RB * n_ok) begin
        errors++; $display("FAIL rand%0d_count: aw=%0d w=%0d ar=%0d expected %0d %0d %0d", it, got_aw.size(), got_w.size(), got_ar.size(), n_wr, n_wr, RB * n_ok); end
      else begin
        bad = 0;
        for (int i = 0; i < n_wr; i++) if (got_aw[i] !== m_addr[i] || got_w[i] !== m_data[i]) bad++;
        checks++; if (bad != 0) begin
          errors++; $display("FAIL rand%0d_order: %0d beats differ from table, expected 0", it, bad); end
      end
      checks++; if (error !== (errb >= 0) || (errb >= 0 && err_idx !== 4'(errb))) begin
        errors++; $display("FAIL rand%0d_error: error=%b err_idx=%0d expected %0d idx %0d", it, error, err_idx, errb >= 0, errb); end
    end
  endtask

  initial begin
    reset = 1; tbl_we = 0; tbl_idx = 0; tbl_addr = 0; tbl_data = 0;
    seq_len = 0; start = 0; frame_sync = 0; eof = 0;
    clear_slave(0, 0, 0, -1, -1, 0);
    test_reset();
    test_basic();
    test_aw_delay();
    test_bresp_error();
    test_timeout();
    test_frame_sync();
    test_zero_len();
    test_busy_ignore();
    test_mid_reset();
    test_readback();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
